// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle MIPS-subset controller.
// Holds the FSM state enum, opcode/funct constants, datapath select
// encodings and the one-hot instruction class produced by mc_decode.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b011;

  localparam logic [2:0] EXT_SIGN = 3'b000;
  localparam logic [2:0] EXT_ZERO = 3'b001;
  localparam logic [2:0] EXT_LUI  = 3'b010;

  localparam logic [2:0] NPC_PC4  = 3'b000;
  localparam logic [2:0] NPC_BR   = 3'b001;
  localparam logic [2:0] NPC_JAL  = 3'b010;
  localparam logic [2:0] NPC_JR   = 3'b011;

  localparam logic [2:0] RA_RD    = 3'b000;
  localparam logic [2:0] RA_RT    = 3'b001;
  localparam logic [2:0] RA_31    = 3'b010;

  localparam logic [2:0] RW_ALU   = 3'b000;
  localparam logic [2:0] RW_EXT   = 3'b001;
  localparam logic [2:0] RW_MDR   = 3'b010;
  localparam logic [2:0] RW_PC4   = 3'b011;

  localparam logic [2:0] AB_RD2   = 3'b000;
  localparam logic [2:0] AB_EXT   = 3'b001;

  typedef struct packed {
    logic add;
    logic sub;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic jal;
    logic jr;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier.
// Ports:
//   special  in  6  opcode IR[31:26]
//   offest   in  6  funct IR[5:0]
//   cls      out    one-hot instruction class (all zero = nop)
//   aluop, extop, absel  out 3  static EXEC selects
//   rasel, rwsel         out 3  static write-back selects
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] special,
  input  logic [5:0] offest,
  output iclass_t    cls,
  output logic [2:0] aluop,
  output logic [2:0] extop,
  output logic [2:0] absel,
  output logic [2:0] rasel,
  output logic [2:0] rwsel
);

  always_comb begin
    cls   = '0;
    aluop = ALU_ADD;
    extop = EXT_SIGN;
    absel = AB_RD2;
    rasel = RA_RD;
    rwsel = RW_ALU;
    case (special)
      OP_RTYPE: begin
        if (offest == FN_ADD) begin
          cls.add = 1'b1;
        end else if (offest == FN_SUB) begin
          cls.sub = 1'b1;
          aluop   = ALU_SUB;
        end else if (offest == FN_JR) begin
          cls.jr = 1'b1;
        end
      end
      OP_ORI: begin
        cls.ori = 1'b1;
        aluop   = ALU_OR;
        extop   = EXT_ZERO;
        absel   = AB_EXT;
        rasel   = RA_RT;
      end
      OP_LW: begin
        cls.lw = 1'b1;
        absel  = AB_EXT;
        rasel  = RA_RT;
        rwsel  = RW_MDR;
      end
      OP_SW: begin
        cls.sw = 1'b1;
        absel  = AB_EXT;
      end
      OP_BEQ: begin
        cls.beq = 1'b1;
        aluop   = ALU_SUB;
      end
      OP_LUI: begin
        cls.lui = 1'b1;
        extop   = EXT_LUI;
        absel   = AB_EXT;
        rasel   = RA_RT;
        rwsel   = RW_EXT;
      end
      OP_JAL: begin
        cls.jal = 1'b1;
        rasel   = RA_31;
        rwsel   = RW_PC4;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle FSM sequencing one instruction through
// FETCH/DECODE/EXEC/MEM/WB over a shared, variable-latency memory port,
// plus a retired-instruction counter (one count per PCWE pulse).
// Ports:
//   clk, rst_n (async active-low); special/offest from IR; zero from ALU;
//   mem_ready/mem_req/mem_instr/DMWN memory handshake; IRWE, MDRWE,
//   PCWE, GRFWE strobes; ALUop/EXTop/NPCop/RAsel/RWsel/ABsel selects;
//   state (debug); instr_count.
//
// state  | meaning
// FETCH  | request instruction at PC, latch IR on mem_ready
// DECODE | register read, no strobes
// EXEC   | ALU op; beq/jal/jr/nop retire here
// MEM    | data access for lw/sw; sw retires here
// WB     | register write for ALU/lui/lw, retire
module mc_control
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  special,
  input  logic [5:0]  offest,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_instr,
  output logic        DMWN,
  output logic        IRWE,
  output logic        MDRWE,
  output logic        PCWE,
  output logic        GRFWE,
  output logic [2:0]  ALUop,
  output logic [2:0]  EXTop,
  output logic [2:0]  NPCop,
  output logic [2:0]  RAsel,
  output logic [2:0]  RWsel,
  output logic [2:0]  ABsel,
  output logic [2:0]  state,
  output logic [31:0] instr_count
);

  state_t     cur, nxt;
  iclass_t    cls;
  logic [2:0] d_aluop, d_extop, d_absel, d_rasel, d_rwsel;
  logic       req, instr, dmwn, irwe, mdrwe, pcwe, grfwe;

  mc_decode u_decode (
    .special (special),
    .offest  (offest),
    .cls     (cls),
    .aluop   (d_aluop),
    .extop   (d_extop),
    .absel   (d_absel),
    .rasel   (d_rasel),
    .rwsel   (d_rwsel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_FETCH;
    else        cur <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    instr_count <= 32'd0;
    else if (pcwe) instr_count <= instr_count + 32'd1;
  end

  always_comb begin
    nxt   = cur;
    req   = 1'b0;
    instr = 1'b0;
    dmwn  = 1'b0;
    irwe  = 1'b0;
    mdrwe = 1'b0;
    pcwe  = 1'b0;
    grfwe = 1'b0;
    ALUop = ALU_ADD;
    EXTop = EXT_SIGN;
    NPCop = NPC_PC4;
    RAsel = RA_RD;
    RWsel = RW_ALU;
    ABsel = AB_RD2;
    case (cur)
      S_FETCH: begin
        req   = 1'b1;
        instr = 1'b1;
        if (mem_ready) begin
          irwe = 1'b1;
          nxt  = S_DECODE;
        end
      end
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        ALUop = d_aluop;
        EXTop = d_extop;
        ABsel = d_absel;
        if (cls.add || cls.sub || cls.ori || cls.lui) begin
          nxt = S_WB;
        end else if (cls.lw || cls.sw) begin
          nxt = S_MEM;
        end else begin
          // beq, jal, jr and unrecognised encodings all retire here
          pcwe = 1'b1;
          nxt  = S_FETCH;
          if (cls.beq) begin
            NPCop = zero ? NPC_BR : NPC_PC4;
          end else if (cls.jal) begin
            grfwe = 1'b1;
            RAsel = d_rasel;
            RWsel = d_rwsel;
            NPCop = NPC_JAL;
          end else if (cls.jr) begin
            NPCop = NPC_JR;
          end
        end
      end
      S_MEM: begin
        req   = 1'b1;
        dmwn  = cls.sw;
        // keep the address computation alive for the whole request
        ALUop = ALU_ADD;
        ABsel = AB_EXT;
        if (mem_ready) begin
          if (cls.lw) begin
            mdrwe = 1'b1;
            nxt   = S_WB;
          end else begin
            pcwe = 1'b1;
            nxt  = S_FETCH;
          end
        end
      end
      S_WB: begin
        grfwe = 1'b1;
        RAsel = d_rasel;
        RWsel = d_rwsel;
        pcwe  = 1'b1;
        nxt   = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // reset parks the FSM in FETCH, whose request must not leak out
  assign mem_req   = req   & rst_n;
  assign mem_instr = instr & rst_n;
  assign DMWN      = dmwn  & rst_n;
  assign IRWE      = irwe  & rst_n;
  assign MDRWE     = mdrwe & rst_n;
  assign PCWE      = pcwe  & rst_n;
  assign GRFWE     = grfwe & rst_n;
  assign state     = cur;

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  special, offest;
  logic        zero, mem_ready;
  logic        mem_req, mem_instr, DMWN, IRWE, MDRWE, PCWE, GRFWE;
  logic [2:0]  ALUop, EXTop, NPCop, RAsel, RWsel, ABsel, state;
  logic [31:0] instr_count;

  int total = 0;
  int bad   = 0;

  // per-instruction observations
  int          cycles, n_irwe, n_mdrwe, n_grf, n_dmwn, dmwn_bad, hold_bad;
  logic [31:0] trace;
  logic [2:0]  g_state, g_rasel, g_rwsel, p_state, p_npcop;
  logic [2:0]  e_aluop, e_extop, e_absel;

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .special(special), .offest(offest),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_instr(mem_instr), .DMWN(DMWN), .IRWE(IRWE), .MDRWE(MDRWE),
    .PCWE(PCWE), .GRFWE(GRFWE), .ALUop(ALUop), .EXTop(EXTop),
    .NPCop(NPCop), .RAsel(RAsel), .RWsel(RWsel), .ABsel(ABsel),
    .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one instruction from FETCH until its PCWE cycle. fw/mw are the
  // number of wait cycles the memory inserts in FETCH and MEM.
  task automatic run_ins(input logic [5:0] sp, input logic [5:0] fn,
                         input logic z, input int fw, input int mw);
    int         wcnt;
    logic [2:0] prev_st;
    logic       pend, done;
    logic [2:0] hold_sig;
    special = sp; offest = fn; zero = z;
    cycles = 0; n_irwe = 0; n_mdrwe = 0; n_grf = 0; n_dmwn = 0;
    dmwn_bad = 0; hold_bad = 0; trace = '0;
    g_state = '1; g_rasel = '1; g_rwsel = '1; p_state = '1; p_npcop = '1;
    wcnt = 0; prev_st = state; pend = 1'b0; hold_sig = '0; done = 1'b0;
    for (int c = 0; c < 24 && !done; c++) begin
      if (state != prev_st) wcnt = 0;
      prev_st = state;
      if (state == 3'd0)      mem_ready = (wcnt >= fw);
      else if (state == 3'd3) mem_ready = (wcnt >= mw);
      else                    mem_ready = 1'b0;
      #1;
      cycles++;
      trace = {trace[28:0], state};
      if (pend && ({mem_req, mem_instr, DMWN} !== hold_sig)) hold_bad++;
      pend     = mem_req && !mem_ready;
      hold_sig = {mem_req, mem_instr, DMWN};
      if (IRWE)  n_irwe++;
      if (MDRWE) n_mdrwe++;
      if (DMWN) begin
        n_dmwn++;
        if (state != 3'd3 || mem_instr) dmwn_bad++;
      end
      if (GRFWE) begin
        n_grf++; g_state = state; g_rasel = RAsel; g_rwsel = RWsel;
      end
      if (state == 3'd2) begin
        e_aluop = ALUop; e_extop = EXTop; e_absel = ABsel;
      end
      if (PCWE) begin
        done = 1'b1; p_state = state; p_npcop = NPCop;
      end
      wcnt++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    chk("retire_in_budget", 32'(done), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; special = '0; offest = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_pcwe", 32'(PCWE), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_mem_req", 32'(mem_req), 32'd1);
    chk("rel_mem_instr", 32'(mem_instr), 32'd1);

    // add, zero wait
    run_ins(6'b000000, 6'b100000, 1'b0, 0, 0);
    chk("add_trace", trace, 32'({3'd0, 3'd1, 3'd2, 3'd4}));
    chk("add_cycles", 32'(cycles), 32'd4);
    chk("add_irwe", 32'(n_irwe), 32'd1);
    chk("add_grf_n", 32'(n_grf), 32'd1);
    chk("add_grf_state", 32'(g_state), 32'd4);
    chk("add_rasel", 32'(g_rasel), 32'd0);
    chk("add_count", instr_count, 32'd1);

    // lw, two wait cycles in FETCH and in MEM
    run_ins(6'b100011, 6'b000000, 1'b0, 2, 2);
    chk("lw_trace", trace,
        32'({3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4}));
    chk("lw_cycles", 32'(cycles), 32'd9);
    chk("lw_hold", 32'(hold_bad), 32'd0);
    chk("lw_mdrwe", 32'(n_mdrwe), 32'd1);
    chk("lw_rwsel", 32'(g_rwsel), 32'd2);
    chk("lw_rasel", 32'(g_rasel), 32'd1);
    chk("lw_count", instr_count, 32'd2);

    run_ins(6'b000000, 6'b100010, 1'b0, 0, 0);
    chk("sub_aluop", 32'(e_aluop), 32'd1);
    chk("sub_absel", 32'(e_absel), 32'd0);
    chk("sub_rasel", 32'(g_rasel), 32'd0);

    run_ins(6'b001101, 6'b000000, 1'b0, 0, 0);
    chk("ori_aluop", 32'(e_aluop), 32'd3);
    chk("ori_extop", 32'(e_extop), 32'd1);
    chk("ori_absel", 32'(e_absel), 32'd1);
    chk("ori_rasel", 32'(g_rasel), 32'd1);

    run_ins(6'b001111, 6'b000000, 1'b0, 0, 0);
    chk("lui_extop", 32'(e_extop), 32'd2);
    chk("lui_rwsel", 32'(g_rwsel), 32'd1);
    chk("lui_cycles", 32'(cycles), 32'd4);

    run_ins(6'b000100, 6'b000000, 1'b1, 0, 0);
    chk("beq1_cycles", 32'(cycles), 32'd3);
    chk("beq1_npcop", 32'(p_npcop), 32'd1);
    chk("beq1_pc_state", 32'(p_state), 32'd2);
    chk("beq1_grf", 32'(n_grf), 32'd0);

    run_ins(6'b000100, 6'b000000, 1'b0, 0, 0);
    chk("beq0_cycles", 32'(cycles), 32'd3);
    chk("beq0_npcop", 32'(p_npcop), 32'd0);

    run_ins(6'b000011, 6'b000000, 1'b0, 0, 0);
    chk("jal_grf_state", 32'(g_state), 32'd2);
    chk("jal_rasel", 32'(g_rasel), 32'd2);
    chk("jal_rwsel", 32'(g_rwsel), 32'd3);
    chk("jal_npcop", 32'(p_npcop), 32'd2);

    run_ins(6'b000000, 6'b001000, 1'b0, 0, 0);
    chk("jr_npcop", 32'(p_npcop), 32'd3);
    chk("jr_grf", 32'(n_grf), 32'd0);
    chk("jr_count", instr_count, 32'd9);

    // sw with one MEM wait cycle
    run_ins(6'b101011, 6'b000000, 1'b0, 0, 1);
    chk("sw_cycles", 32'(cycles), 32'd5);
    chk("sw_dmwn_n", 32'(n_dmwn), 32'd2);
    chk("sw_dmwn_where", 32'(dmwn_bad), 32'd0);
    chk("sw_grf", 32'(n_grf), 32'd0);
    chk("sw_hold", 32'(hold_bad), 32'd0);

    run_ins(6'b111111, 6'b000000, 1'b0, 0, 0);
    chk("nop_cycles", 32'(cycles), 32'd3);
    chk("nop_pc_state", 32'(p_state), 32'd2);
    chk("nop_npcop", 32'(p_npcop), 32'd0);
    chk("nop_count", instr_count, 32'd11);

    // reset while a sw data request is pending
    special = 6'b101011; offest = '0; mem_ready = 1'b1;
    #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_state", 32'(state), 32'd3);
    chk("mid_dmwn", 32'(DMWN), 32'd1);
    chk("mid_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_dmwn", 32'(DMWN), 32'd0);
    chk("mid_rst_strobes", 32'({PCWE, GRFWE, MDRWE, IRWE}), 32'd0);
    chk("mid_rst_state", 32'(state), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_state", 32'(state), 32'd0);
    chk("post_count", instr_count, 32'd0);
    chk("post_req", 32'(mem_req), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
